// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the two-port memory arbiter
// Purpose: FSM state encoding, owner encoding and default access latency.
// Ports: none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  localparam int LATENCY_DEFAULT = 2;

endpackage

// File: rtl/arb_latency_counter.sv
// rtl/arb_latency_counter.sv - 4-bit loadable down-counter with zero flag
// Purpose: counts the remaining ACCESS cycles of the current transfer.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   load, load_val   load count with load_val (takes priority over dec)
//   dec              decrement by one; holds at zero
//   zero             count == 0
module arb_latency_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates a CPU port and a debug port onto one memory
// Purpose: grants one requester at a time, runs a LATENCY-cycle memory access,
//   captures read data and returns a one-cycle ready pulse to the owner.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
//   otherwise the CPU always wins ties.
// Ports:
//   clk, reset                                   clock, sync active-high reset
//   cpu_req/we/addr/wdata -> cpu_rdata/ready     CPU access port
//   dbg_req/we/addr/wdata -> dbg_rdata/ready     debug/loader access port
//   mem_addr/mem_wdata/mem_we, mem_rdata         shared memory port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

  state_t state;
  owner_t owner;
  logic   lat_we;
  logic   any_req;
  logic   grant_dbg;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t last_owner;
`endif

  assign any_req = cpu_req | dbg_req;

  // Debug wins when it is alone, or on a tie when the CPU was served last.
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign grant_dbg = dbg_req && (!cpu_req || (last_owner == OWN_CPU));
`else
  assign grant_dbg = dbg_req && !cpu_req;
`endif

  assign cnt_load = (state == IDLE) && any_req;
  assign cnt_dec  = (state == ACCESS) && !cnt_zero;

  arb_latency_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // mem_addr/mem_wdata double as the latched request address and data; they
  // are loaded on grant and cleared when leaving ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      lat_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_we    <= 1'b0;
      cpu_ready <= 1'b0;
      dbg_ready <= 1'b0;
      cpu_rdata <= 32'd0;
      dbg_rdata <= 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner <= OWN_DBG;
`endif
    end else begin
      case (state)
        IDLE: begin
          cpu_ready <= 1'b0;
          dbg_ready <= 1'b0;
          if (any_req) begin
            owner     <= grant_dbg ? OWN_DBG : OWN_CPU;
            lat_we    <= grant_dbg ? dbg_we : cpu_we;
            mem_addr  <= grant_dbg ? dbg_addr : cpu_addr;
            mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            mem_we    <= grant_dbg ? dbg_we : cpu_we;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner <= grant_dbg ? OWN_DBG : OWN_CPU;
`endif
            state <= ACCESS;
          end
        end
        ACCESS: begin
          // Write strobe lasts for the first ACCESS cycle only.
          mem_we <= 1'b0;
          if (cnt_zero) begin
            if (owner == OWN_CPU) begin
              cpu_ready <= 1'b1;
              if (!lat_we) cpu_rdata <= mem_rdata;
            end else begin
              dbg_ready <= 1'b1;
              if (!lat_we) dbg_rdata <= mem_rdata;
            end
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            state     <= RESP;
          end
        end
        RESP: begin
          cpu_ready <= 1'b0;
          dbg_ready <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic        cpu_ready, dbg_ready, mem_we;
  logic [31:0] l1_cpu_rdata, l1_dbg_rdata, l1_mem_addr, l1_mem_wdata;
  logic        l1_cpu_ready, l1_dbg_ready, l1_mem_we;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(l1_cpu_rdata), .cpu_ready(l1_cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(l1_dbg_rdata), .dbg_ready(l1_dbg_ready),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_we(l1_mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dbg;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    mem_rdata = 32'hBAD0BAD0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    vecs[0] = '{dbg:0, we:0, addr:32'h0000_0100, wdata:32'h0,         mrdata:32'hDEADBEEF, exp_rdata:32'hDEADBEEF};
    vecs[1] = '{dbg:1, we:1, addr:32'h0000_0020, wdata:32'h12345678,  mrdata:32'h0,        exp_rdata:32'h0};
    vecs[2] = '{dbg:1, we:0, addr:32'hFFFF_FFFC, wdata:32'h0,         mrdata:32'hA5A5A5A5, exp_rdata:32'hA5A5A5A5};
    vecs[3] = '{dbg:0, we:1, addr:32'h8000_0000, wdata:32'hCAFEF00D,  mrdata:32'h0,        exp_rdata:32'h0};
    vecs[4] = '{dbg:0, we:0, addr:32'h0000_0004, wdata:32'h0,         mrdata:32'h00000001, exp_rdata:32'h00000001};

    reset = 1;
    idle_inputs();
    tick();
    @(negedge clk);
    check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_dbg_ready", {31'd0, dbg_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);
    tick();
    reset = 0;

    // Single transfers, back to back: cycle 0 IDLE, 1-2 ACCESS, 3 RESP.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].dbg) begin
        dbg_req = 1; dbg_we = vecs[i].we; dbg_addr = vecs[i].addr; dbg_wdata = vecs[i].wdata;
      end else begin
        cpu_req = 1; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
      end
      mem_rdata = 32'hBAD0BAD0;
      for (int c = 0; c <= 3; c++) begin
        @(negedge clk);
        check($sformatf("v%0d_c%0d_mem_addr", i, c), mem_addr,
              (c == 1 || c == 2) ? vecs[i].addr : 32'd0);
        check($sformatf("v%0d_c%0d_mem_we", i, c), {31'd0, mem_we},
              {31'd0, (c == 1) ? vecs[i].we : 1'b0});
        if (vecs[i].we && (c == 1 || c == 2))
          check($sformatf("v%0d_c%0d_mem_wdata", i, c), mem_wdata, vecs[i].wdata);
        check($sformatf("v%0d_c%0d_cpu_ready", i, c), {31'd0, cpu_ready},
              {31'd0, (c == 3) && !vecs[i].dbg});
        check($sformatf("v%0d_c%0d_dbg_ready", i, c), {31'd0, dbg_ready},
              {31'd0, (c == 3) && vecs[i].dbg});
        if (c == 3 && !vecs[i].we)
          check($sformatf("v%0d_rdata", i), vecs[i].dbg ? dbg_rdata : cpu_rdata, vecs[i].exp_rdata);
        tick();
        if (c + 1 == 2) mem_rdata = vecs[i].mrdata;
        if (c + 1 == 3) mem_rdata = 32'h5555AAAA;
        if (c + 1 == 4) begin cpu_req = 0; dbg_req = 0; end
      end
    end
    @(negedge clk);
    check("after_vecs_cpu_rdata_held", cpu_rdata, 32'h00000001);
    check("after_vecs_dbg_rdata_held", dbg_rdata, 32'hA5A5A5A5);
    check("after_vecs_mem_addr", mem_addr, 32'd0);

    // Simultaneous requests after reset: CPU first (ready 3), debug next (ready 7).
    do_reset();
    cpu_req = 1; cpu_addr = 32'h111; dbg_req = 1; dbg_addr = 32'h222; mem_rdata = 32'h0BADCAFE;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) check("tie_c1_mem_addr", mem_addr, 32'h111);
      if (c == 5) check("tie_c5_mem_addr", mem_addr, 32'h222);
      check($sformatf("tie_c%0d_cpu_ready", c), {31'd0, cpu_ready}, {31'd0, c == 3});
      check($sformatf("tie_c%0d_dbg_ready", c), {31'd0, dbg_ready}, {31'd0, c == 7});
      tick();
      if (c + 1 == 4) cpu_req = 0;
      if (c + 1 == 8) dbg_req = 0;
    end

    // CPU re-requests right after its ready while debug is still pending.
    do_reset();
    cpu_req = 1; cpu_addr = 32'h333; dbg_req = 1; dbg_addr = 32'h444;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check($sformatf("rr_c%0d_cpu_ready", c), {31'd0, cpu_ready}, {31'd0, c == 3 || c == 11});
      check($sformatf("rr_c%0d_dbg_ready", c), {31'd0, dbg_ready}, {31'd0, c == 7});
`else
      check($sformatf("fp_c%0d_cpu_ready", c), {31'd0, cpu_ready}, {31'd0, c == 3 || c == 7});
      check($sformatf("fp_c%0d_dbg_ready", c), {31'd0, dbg_ready}, {31'd0, c == 11});
`endif
      tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (c + 1 == 8) dbg_req = 0;
      if (c + 1 == 12) cpu_req = 0;
`else
      if (c + 1 == 8) cpu_req = 0;
      if (c + 1 == 12) dbg_req = 0;
`endif
    end

    // Reset during the second ACCESS cycle aborts the transfer silently.
    do_reset();
    cpu_req = 1; cpu_addr = 32'h300; mem_rdata = 32'hDEAD0001;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c == 2) check("abort_c2_mem_addr", mem_addr, 32'h300);
      if (c == 3) begin
        check("abort_c3_mem_we", {31'd0, mem_we}, 32'd0);
        check("abort_c3_mem_addr", mem_addr, 32'd0);
        check("abort_c3_dbg_ready", {31'd0, dbg_ready}, 32'd0);
        check("abort_c3_cpu_rdata", cpu_rdata, 32'd0);
      end
      if (c >= 3) check($sformatf("abort_c%0d_cpu_ready", c), {31'd0, cpu_ready}, 32'd0);
      tick();
      if (c + 1 == 2) reset = 1;
      if (c + 1 == 3) begin reset = 0; cpu_req = 0; end
    end

    // Debug request raised mid CPU ACCESS is served from the next IDLE.
    do_reset();
    cpu_req = 1; cpu_addr = 32'h400; mem_rdata = 32'h13572468;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c == 5) check("pend_c5_mem_addr", mem_addr, 32'h500);
      if (c == 7) check("pend_dbg_rdata", dbg_rdata, 32'h13572468);
      check($sformatf("pend_c%0d_cpu_ready", c), {31'd0, cpu_ready}, {31'd0, c == 3});
      check($sformatf("pend_c%0d_dbg_ready", c), {31'd0, dbg_ready}, {31'd0, c == 7});
      tick();
      if (c + 1 == 1) begin dbg_req = 1; dbg_addr = 32'h500; end
      if (c + 1 == 4) cpu_req = 0;
      if (c + 1 == 8) dbg_req = 0;
    end

    // LATENCY=1 instance: a single ACCESS cycle, ready in cycle 2.
    do_reset();
    cpu_req = 1; cpu_addr = 32'h600; mem_rdata = 32'hFEEDFACE;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      check($sformatf("l1_c%0d_mem_addr", c), l1_mem_addr, (c == 1) ? 32'h600 : 32'd0);
      check($sformatf("l1_c%0d_cpu_ready", c), {31'd0, l1_cpu_ready}, {31'd0, c == 2});
      check($sformatf("l1_c%0d_dbg_ready", c), {31'd0, l1_dbg_ready}, 32'd0);
      if (c == 2) check("l1_cpu_rdata", l1_cpu_rdata, 32'hFEEDFACE);
      tick();
    end
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2: memory access cycles per transfer, legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  reset; synchronous, active-high.
REQ-004 cpu_req  input  1  CPU (multicycle core) access request; held until cpu_ready.
REQ-005 cpu_we  input  1  CPU write enable; 0 = read.
REQ-006 cpu_addr  input  32  CPU byte address.
REQ-007 cpu_wdata  input  32  CPU write data.
REQ-008 cpu_rdata  output  32  CPU read data; valid while cpu_ready=1.
REQ-009 cpu_ready  output  1  one-cycle completion pulse to CPU; CPU stalls while low.
REQ-010 dbg_req, dbg_we, dbg_addr[31:0], dbg_wdata[31:0]  inputs  debug/loader port; same meanings as the CPU equivalents.
REQ-011 dbg_rdata  output  32, dbg_ready  output  1: same meanings as the CPU equivalents.
REQ-012 mem_addr  output  32  shared memory address.
REQ-013 mem_wdata  output  32  shared memory write data.
REQ-014 mem_we  output  1  shared memory write strobe.
REQ-015 mem_rdata  input  32  shared memory read data; valid in the last ACCESS cycle.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-017 IDLE: if any request is present, the arbiter SHALL pick an owner, latch that requester's we/addr/wdata, load the counter with LATENCY-1, and move to ACCESS.
REQ-018 ACCESS: mem_addr and mem_wdata SHALL be driven from the latched values for exactly LATENCY cycles.
REQ-019 In ACCESS, mem_we SHALL equal the latched we in the first ACCESS cycle only, and SHALL be 0 in all other cycles.
REQ-020 In the ACCESS cycle where the counter is 0, mem_rdata SHALL be captured into the owner's rdata register and the FSM SHALL move to RESP; otherwise the counter SHALL decrement.
REQ-021 RESP: the owner's ready SHALL be 1 for exactly one cycle, the other ready SHALL be 0, and the FSM SHALL return to IDLE.
REQ-022 Latency: a request first seen in IDLE at cycle 0 SHALL get its ready pulse at cycle LATENCY+1.
REQ-023 Requesters drop req at the edge where ready is sampled; back-to-back requests SHALL be accepted in the IDLE cycle after RESP.
REQ-024 Requests arriving during ACCESS or RESP SHALL be held pending, not dropped, and served from the next IDLE.
REQ-025 rdata outputs SHALL hold their last captured value until the next completion for that port; the outputs for a write transfer are don't-care.
REQ-026 mem_addr/mem_wdata SHALL be 0 in IDLE and RESP; mem_we SHALL be 0 outside ACCESS.
REQ-027 A ready pulse SHALL never be issued to a port that was not the latched owner.

Reset
REQ-028 On Reset=1 at a clock edge, the FSM SHALL go to IDLE and the counter to 0, even mid-ACCESS or mid-RESP.
REQ-029 On that reset, cpu_ready, dbg_ready and mem_we SHALL be 0, the rdata registers 0x00000000, and last_owner DBG so the CPU wins the first tie.
REQ-030 A transfer aborted by reset SHALL never produce a ready pulse, and reset SHALL take priority over all other events in the same cycle.

Configuration
REQ-031 With macro MEM_ARB_ROUND_ROBIN_EN defined, a tie in IDLE SHALL go to the port that is not last_owner, and last_owner SHALL update on each grant.
REQ-032 With MEM_ARB_ROUND_ROBIN_EN undefined, the CPU SHALL always win ties (fixed priority) and no last_owner register SHALL exist.

Structure
REQ-033 Shared package mem_arb_pkg SHALL hold the state encoding (IDLE/ACCESS/RESP), the owner encoding (OWN_CPU/OWN_DBG) and the LATENCY default constant.
REQ-034 One sub-module, arb_latency_counter (load, decrement, zero flag, width 4), SHALL be instantiated; all other logic SHALL stay in mem_arbiter.

Verification (LATENCY=2 unless stated)
REQ-035 CPU read, addr 0x100, mem_rdata=0xDEADBEEF -> mem_addr=0x100 in cycles 1-2; cpu_ready=1 with cpu_rdata=0xDEADBEEF in cycle 3; dbg_ready stays 0.
REQ-036 Debug write, addr 0x20, wdata 0x12345678 -> mem_we=1 only in cycle 1, mem_wdata=0x12345678 in cycles 1-2; dbg_ready pulses in cycle 3.
REQ-037 Both request at cycle 0 after reset -> cpu_ready in cycle 3 and dbg_ready in cycle 7. With the macro, a second simultaneous pair goes DBG first; without it, CPU goes first.
REQ-038 Reset asserted in the second ACCESS cycle -> next cycle is IDLE with all readys 0 and mem_we 0, and no ready pulse ever follows for that transfer.
REQ-039 LATENCY=1, CPU read -> one ACCESS cycle; cpu_ready in cycle 2.
REQ-040 dbg_req raised during a CPU ACCESS -> DBG is granted in the IDLE cycle after the CPU's RESP, and no request is lost.
